sema_requester: RTL and testbench

- Bus-master front end that turns a core's "acquire N" / "release N" semaphore requests into the single-beat bus accesses the semaphore memory understands.
- Acquire issues a decrement read. On insufficient count it gives back the partially consumed units, backs off exponentially and retries.
- Sits between a CPU or DMA port and the semaphore memory slave. One request is in flight at a time.

---
 rtl/sema_requester_if.sv | 12 +
 rtl/sema_requester.sv | 104 ++++++++++
 tb/tb_sema_requester.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sema_requester_if.sv
// sema_requester_if: single-beat bus between the requester and the semaphore memory
interface sema_requester_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [12:0] adr_o;
  logic [7:0]  dat_o;
  logic        ack_i;
  logic [7:0]  dat_i;
  modport master(output cyc_o, stb_o, we_o, adr_o, dat_o, input ack_i, dat_i);
  modport slave(input cyc_o, stb_o, we_o, adr_o, dat_o, output ack_i, dat_i);
endinterface

// File: rtl/sema_requester.sv
// sema_requester: turns acquire/release requests into decrement/increment bus accesses with backoff
module sema_requester #(
  parameter int BACKOFF_INIT = 4,
  parameter int BACKOFF_MAX  = 256,
  parameter int MAX_TRIES    = 0,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       rel_i,
  input  logic [7:0] sema_i,
  input  logic [3:0] cnt_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       granted_o,
  output logic       err_o,
  output logic [7:0] val_o,
  sema_requester_if.master bus
);
  typedef enum logic [2:0] {IDLE, DEC, GAP, RESTORE, BACKOFF, INC, DONE} state_t;
  state_t      r_state, w_nxt;
  logic [7:0]  r_sema, r_val;
  logic [3:0]  r_cnt;
  logic        r_rst, r_granted, r_err;
  logic [15:0] r_tmr, r_bo, r_tries;
  logic        w_acc, w_to, w_exh, w_bo_end;
  assign w_acc    = r_state inside {DEC, RESTORE, INC};
  assign w_to     = w_acc && !bus.ack_i && r_tmr == 16'(ACK_TIMEOUT - 1);
  assign w_exh    = MAX_TRIES != 0 && r_tries == 16'(MAX_TRIES);
  assign w_bo_end = r_tmr == r_bo - 16'd1;
  assign bus.cyc_o = w_acc;
  assign bus.stb_o = w_acc;
  assign bus.we_o  = r_state inside {RESTORE, INC};
  assign bus.adr_o = {1'b0, r_sema, r_state == RESTORE ? r_val[3:0] : r_cnt};
  assign bus.dat_o = '0;
  assign busy_o    = r_state != IDLE;
  assign done_o    = r_state == DONE;
  assign granted_o = r_granted;
  assign err_o     = r_err;
  assign val_o     = r_val;
  // state register; reset drops the bus immediately since cyc/stb decode from state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  // next-state: a read returning zero skips the restore, a partial read restores after the gap
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (req_i) w_nxt = cnt_i == 4'd0 ? DONE : rel_i ? INC : DEC;
      DEC:     if (bus.ack_i) w_nxt = bus.dat_i == 8'd0 ? BACKOFF : GAP;
               else if (w_to) w_nxt = DONE;
      GAP:     w_nxt = r_rst ? RESTORE : DONE;
      RESTORE: if (bus.ack_i) w_nxt = BACKOFF;
               else if (w_to) w_nxt = DONE;
      INC:     if (bus.ack_i) w_nxt = GAP;
               else if (w_to) w_nxt = DONE;
      BACKOFF: if (w_exh) w_nxt = DONE;
               else if (w_bo_end) w_nxt = DEC;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  // datapath: request latch, read result, shared ack-timeout/backoff timer, doubling backoff
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sema    <= '0;
      r_cnt     <= '0;
      r_val     <= '0;
      r_rst     <= 1'b0;
      r_granted <= 1'b0;
      r_err     <= 1'b0;
      r_tmr     <= '0;
      r_bo      <= 16'(BACKOFF_INIT);
      r_tries   <= '0;
    end else begin
      r_tmr <= w_nxt != r_state ? '0 : r_tmr + 16'd1;
      if (w_to) r_err <= 1'b1;
      case (r_state)
        IDLE: if (req_i) begin
          r_sema    <= sema_i;
          r_cnt     <= cnt_i;
          r_rst     <= 1'b0;
          r_err     <= 1'b0;
          r_granted <= cnt_i == 4'd0 && !rel_i;
        end
        DEC: if (bus.ack_i) begin
          r_val     <= bus.dat_i;
          r_tries   <= r_tries + 16'd1;
          r_granted <= bus.dat_i >= {4'd0, r_cnt};
          r_rst     <= bus.dat_i < {4'd0, r_cnt};
        end
        BACKOFF: if (w_exh) r_err <= 1'b1;
          else if (w_bo_end) r_bo <= r_bo >= 16'(BACKOFF_MAX / 2) ? 16'(BACKOFF_MAX) : r_bo << 1;
        DONE: begin
          r_bo    <= 16'(BACKOFF_INIT);
          r_tries <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sema_requester.sv
// tb_sema_requester: randomized scoreboard bench with a semaphore memory slave model
module tb_sema_requester;
  localparam int BI = 4;
  localparam int BM = 256;
  localparam int MT = 3;
  localparam int AT = 64;

  typedef struct {
    logic [7:0] s;
    logic       g;
    logic       err;
    logic [7:0] val;
    logic [7:0] mem;
    int         rd;
    int         wr;
    int         adr;
    int         lat;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       rel = 1'b0;
  logic [7:0] sema = '0;
  logic [3:0] cnt = '0;
  logic       busy, done, granted, err;
  logic [7:0] val;

  sema_requester_if bus();

  sema_requester #(.BACKOFF_INIT(BI), .BACKOFF_MAX(BM), .MAX_TRIES(MT), .ACK_TIMEOUT(AT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .rel_i(rel), .sema_i(sema), .cnt_i(cnt),
    .busy_o(busy), .done_o(done), .granted_o(granted), .err_o(err), .val_o(val), .bus(bus));

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         ncyc = 0;
  logic [7:0] mem [256];
  int         rd_cnt = 0, wr_cnt = 0, rd_base = 0, wr_base = 0;
  int         last_adr = -1;
  int         wmax = 0;
  int         wt = 0;
  bit         hung = 1'b0;
  logic [7:0] last_val = '0;
  exp_t       exp_q[$];
  bit         p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [12:0] p_adr = '0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, ncyc);
    end
  endtask

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] n);
    return (9'(a) + 9'(n) > 9'd255) ? 8'd255 : a + 8'(n);
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [3:0] n);
    return a > 8'(n) ? a - 8'(n) : 8'd0;
  endfunction

  // cycles from request sample to done_o for an acquire that exhausts all tries, zero-wait slave
  function automatic int fail_lat(input int v);
    int l = 1;
    int bo = BI;
    for (int k = 0; k < MT; k++) begin
      l += 2 + (v > 0 ? 3 : 0) + (k < MT - 1 ? bo : 1);
      bo = bo * 2 > BM ? BM : bo * 2;
    end
    return l;
  endfunction

  always @(posedge clk) ncyc <= ncyc + 1;

  // semaphore memory slave: read = saturating decrement returning old value, write = saturating increment
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack_i <= 1'b0;
      bus.dat_i <= '0;
    end else if (!bus.stb_o) begin
      bus.ack_i <= 1'b0;
      wt = int'($urandom_range(wmax, 0));
    end else if (bus.ack_i || hung) begin
      bus.ack_i <= 1'b0;
    end else if (wt > 0) begin
      wt = wt - 1;
    end else begin
      bus.ack_i <= 1'b1;
      last_adr = int'(bus.adr_o);
      if (bus.we_o) begin
        mem[bus.adr_o[11:4]] = sat_add(mem[bus.adr_o[11:4]], bus.adr_o[3:0]);
        wr_cnt++;
      end else begin
        bus.dat_i <= mem[bus.adr_o[11:4]];
        mem[bus.adr_o[11:4]] = sat_sub(mem[bus.adr_o[11:4]], bus.adr_o[3:0]);
        rd_cnt++;
      end
    end
  end

  // monitor: bus protocol checks and scoreboard compare on every done_o
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p_stb = 1'b0;
      p_ack = 1'b0;
    end else begin
      if (bus.stb_o || bus.cyc_o) begin
        chk("cyc_eq_stb", int'(bus.cyc_o), int'(bus.stb_o));
        chk("adr12_zero", int'(bus.adr_o[12]), 0);
        chk("dat_o_zero", int'(bus.dat_o), 0);
        if (p_ack) chk("stb_gap_after_ack", int'(bus.stb_o), 0);
        if (p_stb && !p_ack) begin
          chk("adr_stable", int'(bus.adr_o), int'(p_adr));
          chk("we_stable", int'(bus.we_o), int'(p_we));
        end
      end
      p_stb = bus.stb_o;
      p_ack = bus.ack_i;
      p_adr = bus.adr_o;
      p_we  = bus.we_o;
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("granted", int'(granted), int'(e.g));
          chk("err", int'(err), int'(e.err));
          chk("val", int'(val), int'(e.val));
          chk("mem", int'(mem[e.s]), int'(e.mem));
          chk("reads", rd_cnt - rd_base, e.rd);
          chk("writes", wr_cnt - wr_base, e.wr);
          if (e.adr >= 0) chk("last_adr", last_adr, e.adr);
          if (e.lat >= 0) chk("latency", ncyc - e.t0, e.lat);
        end
        rd_base = rd_cnt;
        wr_base = wr_cnt;
      end
    end
  end

  // reference model: outcome of a whole request from the memory contents at issue time
  task automatic issue(input logic r, input logic [7:0] s, input logic [3:0] n, input bit wz,
                       input bit b2b, input int ext);
    exp_t e;
    int v;
    v = int'(mem[s]);
    e.s = s; e.g = 1'b0; e.err = 1'b0; e.val = last_val; e.mem = mem[s];
    e.rd = 0; e.wr = 0; e.adr = -1; e.lat = -1; e.t0 = 0;
    if (n == 4'd0) begin
      e.g = !r;
      e.lat = 1;
    end else if (hung) begin
      e.err = 1'b1;
      e.lat = AT + 1;
    end else if (r) begin
      e.mem = sat_add(mem[s], n);
      e.wr = 1; e.adr = int'({s, n}); e.lat = 4;
    end else if (v >= int'(n)) begin
      e.g = 1'b1; e.val = mem[s]; e.mem = mem[s] - 8'(n);
      e.rd = 1; e.adr = int'({s, n}); e.lat = 4;
    end else if (ext >= 0) begin
      e.g = 1'b1; e.val = 8'(ext); e.mem = 8'(ext - int'(n));
      e.rd = 2; e.wr = 1; e.adr = int'({s, n}); e.lat = 9 + BI;
    end else begin
      e.err = 1'b1; e.val = mem[s]; e.rd = MT; e.wr = v > 0 ? MT : 0;
      e.adr = v > 0 ? int'({s, v[3:0]}) : int'({s, n});
      e.lat = fail_lat(v);
    end
    if (!wz) e.lat = -1;
    last_val = e.val;
    req = 1'b1; rel = r; sema = s; cnt = n;
    if (b2b) @(negedge clk);
    e.t0 = ncyc;
    exp_q.push_back(e);
  endtask

  // waits for completion while scrambling the request inputs, which must be ignored while busy
  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        sema = 8'($urandom);
        cnt  = 4'($urandom);
        rel  = 1'($urandom);
      end
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic go_idle();
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int wr0;
    bit w;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_granted", int'(granted), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_val", int'(val), 0);
    chk("rst_cyc", int'(bus.cyc_o), 0);
    chk("rst_stb", int'(bus.stb_o), 0);
    chk("rst_we", int'(bus.we_o), 0);
    chk("rst_adr", int'(bus.adr_o), 0);
    rst = 1'b0;
    @(negedge clk);

    mem[5] = 8'd3;
    issue(1'b0, 8'h05, 4'd2, 1'b1, 1'b0, -1);
    wait_done();

    go_idle();
    mem[7] = 8'd1;
    wr0 = wr_cnt;
    issue(1'b0, 8'h07, 4'd4, 1'b1, 1'b0, 10);
    w = 1'b0;
    for (int k = 0; k < 100 && !w; k++) begin
      @(negedge clk);
      if (wr_cnt != wr0) w = 1'b1;
    end
    chk("restore_seen", int'(w), 1);
    mem[7] = 8'd10;
    wait_done();

    go_idle();
    mem[2] = 8'd0;
    issue(1'b0, 8'h02, 4'd1, 1'b1, 1'b0, -1);
    wait_done();

    go_idle();
    mem[8'hFF] = 8'd250;
    issue(1'b1, 8'hFF, 4'd15, 1'b1, 1'b0, -1);
    wait_done();

    go_idle();
    hung = 1'b1;
    issue(1'b0, 8'h03, 4'd1, 1'b1, 1'b0, -1);
    wait_done();
    hung = 1'b0;

    go_idle();
    issue(1'b0, 8'h09, 4'd0, 1'b1, 1'b0, -1);
    wait_done();

    go_idle();
    mem[4] = 8'd9;
    issue(1'b0, 8'h04, 4'd1, 1'b1, 1'b0, -1);
    w = 1'b0;
    for (int k = 0; k < 10 && !w; k++) begin
      @(negedge clk);
      if (bus.stb_o) w = 1'b1;
    end
    chk("stb_seen", int'(w), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_cyc", int'(bus.cyc_o), 0);
    chk("arst_stb", int'(bus.stb_o), 0);
    chk("arst_busy", int'(busy), 0);
    exp_q.delete();
    req = 1'b0;
    last_val = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_val", int'(val), 0);
    chk("arst_mem_untouched", int'(mem[4]), 9);
    issue(1'b0, 8'h04, 4'd1, 1'b1, 1'b0, -1);
    wait_done();

    for (int i = 0; i < 150; i++) begin
      logic [7:0] s;
      logic [3:0] n;
      logic r;
      bit b2b;
      s = 8'($urandom_range(7, 0));
      n = 4'($urandom_range(15, 0));
      r = ($urandom % 3) == 0;
      b2b = 1'($urandom);
      if (!b2b) begin
        go_idle();
        if ($urandom % 2 == 0) mem[s] = 8'($urandom_range(20, 0));
      end
      wmax = ($urandom % 2 == 0) ? 0 : 2;
      issue(r, s, n, wmax == 0, b2b, -1);
      wait_done();
    end

    req = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
